// File: rtl/inexrecur_seq_fetch.sv
// ----------------------------------------------------------------------------
// inexrecur_seq_fetch
// Drains a requested number of entries from the inexact-recursion register
// file with sequential-read pulses, captures each returned word together with
// its address, splits it into the i/z/k/l byte parameters and offers the
// result on a valid/ready stream. Reads are only issued when the output FIFO
// is guaranteed to have room for the return, so downstream stalls never lose
// data.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, entry_cnt  begin a drain of entry_cnt (0..4096) entries, IDLE only
//   flush             synchronous abort, highest priority
//   busy, done        busy in RUN/DRAIN; done pulses once at drain end
//   seq_re            registered sequential-read enable to the register file
//   seq_r_data/addr   returned word and its address, RD_LAT after seq_re
//   out_valid/ready   output handshake
//   out_i/z/k/l/addr  unpacked head entry; out_last marks the final entry
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing reads while credit is available
// DRAIN | all reads issued, waiting for downstream to accept the rest
// DONE  | one-cycle done pulse
// ----------------------------------------------------------------------------
module inexrecur_seq_fetch #(
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [12:0] entry_cnt,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic        seq_re,
   input  logic [31:0] seq_r_data,
   input  logic [11:0] seq_r_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_i,
   output logic [7:0]  out_z,
   output logic [7:0]  out_k,
   output logic [7:0]  out_l,
   output logic [11:0] out_addr,
   output logic        out_last
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [7:0] DEPTH_V = 8'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [12:0] n_q, n_d;
   logic [12:0] issued_q, issued_d;
   logic [12:0] accepted_q, accepted_d;
   logic        seq_re_q, seq_re_d;
   logic [RD_LAT-1:0] pipe_q;
   logic [1:0]  discard_q, discard_d;

   logic [43:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;

   logic        pop, ret, push;
   logic [7:0]  pend, occ;
   logic [1:0]  late;
   logic [43:0] head;

   assign pop  = (cnt_q != '0) & out_ready;
   assign ret  = pipe_q[RD_LAT-1];
   assign push = ret & (discard_q == 2'd0) & ~flush;

   // pend: reads issued whose data has not yet landed in the FIFO (including
   // the one landing this cycle). late: reads that will return after this
   // cycle, i.e. what a flush now must discard.
   always_comb begin
      pend = {7'd0, seq_re_q};
      for (int k = 0; k < RD_LAT; k++) pend = pend + {7'd0, pipe_q[k]};
      late = {1'b0, seq_re_q};
      for (int k = 0; k < RD_LAT - 1; k++) late = late + {1'b0, pipe_q[k]};
      // Worst-case occupancy once everything outstanding has arrived;
      // a same-cycle pop frees a slot immediately.
      occ = {{(8-CW){1'b0}}, cnt_q} - {7'd0, pop} + pend;
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      issued_d   = issued_q;
      accepted_d = accepted_q + {12'd0, pop};
      seq_re_d   = 1'b0;
      discard_d  = (ret && discard_q != 2'd0) ? discard_q - 2'd1 : discard_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d        = entry_cnt;
               issued_d   = 13'd0;
               accepted_d = 13'd0;
               if (entry_cnt == 13'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d  = S_RUN;
                  seq_re_d = (occ < DEPTH_V);
                  issued_d = {12'd0, seq_re_d};
               end
            end
         end
         S_RUN: begin
            if (issued_q == n_q) begin
               state_d = S_DRAIN;
            end else begin
               seq_re_d = (occ < DEPTH_V);
               issued_d = issued_q + {12'd0, seq_re_d};
            end
         end
         S_DRAIN: if (accepted_q == n_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d    = S_IDLE;
         seq_re_d   = 1'b0;
         issued_d   = 13'd0;
         accepted_d = 13'd0;
         discard_d  = late;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         n_q        <= 13'd0;
         issued_q   <= 13'd0;
         accepted_q <= 13'd0;
         seq_re_q   <= 1'b0;
         pipe_q     <= '0;
         discard_q  <= 2'd0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         seq_re_q   <= seq_re_d;
         discard_q  <= discard_d;
         pipe_q[0]  <= seq_re_q;
         for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= 44'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {seq_r_data, seq_r_addr};
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (cnt_q != '0);
   assign out_i     = head[43:36];
   assign out_z     = head[35:28];
   assign out_k     = head[27:20];
   assign out_l     = head[19:12];
   assign out_addr  = head[11:0];
   assign out_last  = out_valid & (accepted_q == n_q - 13'd1);
   assign seq_re    = seq_re_q;
   assign busy      = (state_q == S_RUN) | (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_inexrecur_seq_fetch.sv
module tb_inexrecur_seq_fetch;

   localparam int DEPTH = 4;
   localparam int LAT0  = 1;
   localparam int LAT1  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, flush, out_ready;
   logic [12:0] entry_cnt;
   logic        busy_w [2], done_w [2], seq_re_w [2], valid_w [2], last_w [2];
   logic [31:0] rdata_w [2];
   logic [11:0] raddr_w [2];
   logic [7:0]  oi_w [2], oz_w [2], ok_w [2], ol_w [2];
   logic [11:0] oaddr_w [2];

   int checks = 0;
   int errors = 0;

   inexrecur_seq_fetch #(.RD_LAT(LAT0), .FIFO_DEPTH(DEPTH)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .start(start), .entry_cnt(entry_cnt), .flush(flush),
      .busy(busy_w[0]), .done(done_w[0]), .seq_re(seq_re_w[0]),
      .seq_r_data(rdata_w[0]), .seq_r_addr(raddr_w[0]),
      .out_valid(valid_w[0]), .out_ready(out_ready),
      .out_i(oi_w[0]), .out_z(oz_w[0]), .out_k(ok_w[0]), .out_l(ol_w[0]),
      .out_addr(oaddr_w[0]), .out_last(last_w[0]));

   inexrecur_seq_fetch #(.RD_LAT(LAT1), .FIFO_DEPTH(DEPTH)) u_dut_l3 (
      .clk(clk), .rst_n(rst_n), .start(start), .entry_cnt(entry_cnt), .flush(flush),
      .busy(busy_w[1]), .done(done_w[1]), .seq_re(seq_re_w[1]),
      .seq_r_data(rdata_w[1]), .seq_r_addr(raddr_w[1]),
      .out_valid(valid_w[1]), .out_ready(out_ready),
      .out_i(oi_w[1]), .out_z(oz_w[1]), .out_k(ok_w[1]), .out_l(ol_w[1]),
      .out_addr(oaddr_w[1]), .out_last(last_w[1]));

   // Register-file model: each seq_re reads the next address; the word comes
   // back after the instance's read latency. Stored as {valid, addr, data}.
   logic        rf_load;
   logic [11:0] rf_base;
   logic [31:0] rf_key;
   logic [11:0] rf_ptr [2];
   logic [11:0] rf_cur [2];
   logic [44:0] dl [2][3];

   function automatic logic [31:0] word_of(input logic [31:0] key, input logic [11:0] a);
      return key ^ (32'h1122_3344 + {20'd0, a});
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         rf_cur[d] = rf_load ? rf_base : rf_ptr[d];
         dl[d][2] <= dl[d][1];
         dl[d][1] <= dl[d][0];
         if (seq_re_w[d]) begin
            dl[d][0]  <= {1'b1, rf_cur[d], word_of(rf_key, rf_cur[d])};
            rf_ptr[d] <= rf_cur[d] + 12'd1;
         end else begin
            dl[d][0]  <= 45'd0;
            rf_ptr[d] <= rf_cur[d];
         end
      end
   end

   assign rdata_w[0] = dl[0][LAT0-1][44] ? dl[0][LAT0-1][31:0]  : 32'hDEAD_BEEF;
   assign raddr_w[0] = dl[0][LAT0-1][44] ? dl[0][LAT0-1][43:32] : 12'hFFF;
   assign rdata_w[1] = dl[1][LAT1-1][44] ? dl[1][LAT1-1][31:0]  : 32'hDEAD_BEEF;
   assign raddr_w[1] = dl[1][LAT1-1][44] ? dl[1][LAT1-1][43:32] : 12'hFFF;

   // One drain: expected stream is base..base+n-1 with words from word_of, in
   // order, out_last on the final one, exactly one done after the last accept.
   task automatic run_drain(input string tag, input int n, input int ready_pct, input int stall,
                            input int restart_k, input logic [11:0] base, input logic [31:0] key);
      int idx [2], done_cnt [2], done_k [2], first_k [2], last_k [2], stall_re [2];
      bit fin;
      int budget, lat;
      logic [11:0] ea;
      logic [44:0] exp_v, got_v;
      for (int d = 0; d < 2; d++) begin
         idx[d] = 0; done_cnt[d] = 0; done_k[d] = -1; first_k[d] = -1; last_k[d] = -1; stall_re[d] = 0;
      end
      rf_base = base; rf_key = key; rf_load = 1'b1;
      entry_cnt = 13'(n); start = 1'b1;
      budget = 3 * n + 60 + stall;
      fin = 1'b0;
      for (int k = 1; k <= budget && !fin; k++) begin
         @(negedge clk);
         rf_load = 1'b0;
         start = (k == restart_k);
         if (k == restart_k) entry_cnt = 13'd7;
         out_ready = (k <= stall) ? 1'b0 : ($urandom_range(99) < ready_pct);
         for (int d = 0; d < 2; d++) begin
            if (k <= stall && seq_re_w[d]) stall_re[d]++;
            checks++;
            if (valid_w[d]) begin
               if (idx[d] >= n) begin
                  errors++;
                  $display("FAIL %s dut%0d extra_entry: got addr %h, required no entry beyond %0d", tag, d, oaddr_w[d], n);
               end else begin
                  ea = base + 12'(idx[d]);
                  exp_v = {word_of(key, ea), ea, (idx[d] == n - 1)};
                  got_v = {oi_w[d], oz_w[d], ok_w[d], ol_w[d], oaddr_w[d], last_w[d]};
                  if (got_v !== exp_v) begin
                     errors++;
                     $display("FAIL %s dut%0d head[%0d]: got %h, required %h", tag, d, idx[d], got_v, exp_v);
                  end
               end
               if (out_ready) begin
                  if (first_k[d] < 0) first_k[d] = k;
                  last_k[d] = k;
                  idx[d]++;
               end
            end else if (last_w[d] !== 1'b0) begin
               errors++;
               $display("FAIL %s dut%0d last_without_valid: got %b, required 0", tag, d, last_w[d]);
            end
            if (done_w[d]) begin
               done_cnt[d]++;
               done_k[d] = k;
            end
         end
         fin = (done_cnt[0] > 0) && (done_cnt[1] > 0) &&
               (k >= done_k[0] + 3) && (k >= done_k[1] + 3);
      end
      out_ready = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s timeout: drain not finished within %0d cycles, required done", tag, budget);
      end
      for (int d = 0; d < 2; d++) begin
         lat = (d == 0) ? LAT0 : LAT1;
         checks++;
         if (idx[d] != n) begin
            errors++;
            $display("FAIL %s dut%0d transfer_count: got %0d, required %0d", tag, d, idx[d], n);
         end
         checks++;
         if (done_cnt[d] != 1) begin
            errors++;
            $display("FAIL %s dut%0d done_count: got %0d, required 1", tag, d, done_cnt[d]);
         end
         checks++;
         if (done_k[d] <= last_k[d] || done_k[d] > last_k[d] + 2) begin
            errors++;
            $display("FAIL %s dut%0d done_timing: got cycle %0d, required 1..2 after last accept %0d", tag, d, done_k[d], last_k[d]);
         end
         if (stall > 0) begin
            checks++;
            if (stall_re[d] != DEPTH) begin
               errors++;
               $display("FAIL %s dut%0d stall_reads: got %0d, required %0d", tag, d, stall_re[d], DEPTH);
            end
         end
         if (ready_pct == 100 && stall == 0) begin
            checks++;
            if (first_k[d] != lat + 2) begin
               errors++;
               $display("FAIL %s dut%0d first_valid_latency: got %0d, required %0d", tag, d, first_k[d], lat + 2);
            end
            if (d == 0) begin
               checks++;
               if (last_k[d] != first_k[d] + n - 1) begin
                  errors++;
                  $display("FAIL %s dut%0d throughput: last accept at %0d, required %0d", tag, d, last_k[d], first_k[d] + n - 1);
               end
            end
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy_w[d], done_w[d], seq_re_w[d], valid_w[d], last_w[d],
              oi_w[d], oz_w[d], ok_w[d], ol_w[d], oaddr_w[d]} !== 49'd0) begin
            errors++;
            $display("FAIL %s dut%0d outputs: got busy=%b done=%b re=%b v=%b last=%b data=%h%h%h%h addr=%h, required all 0",
                     tag, d, busy_w[d], done_w[d], seq_re_w[d], valid_w[d], last_w[d],
                     oi_w[d], oz_w[d], ok_w[d], ol_w[d], oaddr_w[d]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; entry_cnt = 13'd0; out_ready = 1'b0;
      rf_load = 1'b0; rf_base = 12'd0; rf_key = 32'd0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_quiet("after_reset");
   endtask

   task automatic test_basic();
      run_drain("basic5", 5, 100, 0, 0, 12'h000, 32'h0);
   endtask

   task automatic test_zero();
      int dcnt [2], dk [2];
      for (int d = 0; d < 2; d++) begin dcnt[d] = 0; dk[d] = -1; end
      entry_cnt = 13'd0; start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_w[d], seq_re_w[d], valid_w[d]} !== 3'b000) begin
               errors++;
               $display("FAIL zero dut%0d activity: got busy=%b re=%b v=%b, required 0", d, busy_w[d], seq_re_w[d], valid_w[d]);
            end
            if (done_w[d]) begin dcnt[d]++; dk[d] = k; end
         end
      end
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dcnt[d] != 1 || dk[d] < 1 || dk[d] > 2) begin
            errors++;
            $display("FAIL zero dut%0d done: got %0d pulses at cycle %0d, required 1 pulse within 2 cycles", d, dcnt[d], dk[d]);
         end
      end
   endtask

   task automatic test_stall();
      run_drain("stall16", 16, 100, 20, 0, 12'h3F8, $urandom);
   endtask

   task automatic test_back_to_back();
      run_drain("b2b_a", 9, 60, 0, 0, 12'h7F0, $urandom);
      run_drain("b2b_b", 4, 100, 0, 0, 12'h012, $urandom);
   endtask

   task automatic test_flush();
      rf_base = 12'h100; rf_key = $urandom; rf_load = 1'b1;
      entry_cnt = 13'd10; start = 1'b1; out_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         rf_load = 1'b0; start = 1'b0;
         if (k == 1) begin
            for (int d = 0; d < 2; d++) begin
               checks++;
               if (seq_re_w[d] !== 1'b1) begin
                  errors++;
                  $display("FAIL flush dut%0d first_read: got %b, required 1", d, seq_re_w[d]);
               end
            end
         end
         if (k == 3) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({valid_w[d], seq_re_w[d], busy_w[d], done_w[d]} !== 4'b0000) begin
            errors++;
            $display("FAIL flush dut%0d after_flush: got v=%b re=%b busy=%b done=%b, required 0",
                     d, valid_w[d], seq_re_w[d], busy_w[d], done_w[d]);
         end
      end
      run_drain("flush_restart", 3, 100, 0, 0, 12'h200, $urandom);
   endtask

   task automatic test_reset_mid();
      rf_base = 12'h440; rf_key = $urandom; rf_load = 1'b1;
      entry_cnt = 13'd20; start = 1'b1; out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         rf_load = 1'b0; start = 1'b0;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_quiet("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_quiet("idle_after_reset");
      end
      run_drain("after_reset", 6, 70, 0, 0, 12'h0A0, $urandom);
   endtask

   task automatic test_random_4096();
      run_drain("full4096", 4096, 50, 0, 10, 12'h000, $urandom);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_stall();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random_4096();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
